// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_cfg_pkg / mem_responder_pkg
// Description : Shared configuration defaults and wire-level types for the
//               dual-port memory responder.
//               mem_responder_cfg_pkg : default storage depth and wait states.
//               mem_responder_pkg     : FSM state enum, request/response
//                                       structs and an address range helper.
// Revision    : 1.0 - initial release
// ============================================================================

package mem_responder_cfg_pkg;

    // Storage depth in 32-bit words (power of two).
    localparam int unsigned c_MEM_DEPTH_DEFAULT   = 4096;
    // Extra latency cycles inserted between grant and response (0..15).
    localparam int unsigned c_WAIT_STATES_DEFAULT = 1;

endpackage : mem_responder_cfg_pkg

package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // One requester port as seen by the responder.
    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } responder_in_t;

    // Response returned to one requester port.
    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
    } responder_out_t;

    // True when the word index addr[31:2] falls inside the storage.
    function automatic logic word_in_range(input logic [31:0] addr,
                                           input int unsigned depth);
        return ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage : mem_responder_pkg
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : responder_ram
// Description : Single-port 32-bit storage with per-byte write enables and a
//               registered read. A full strobe writes the whole word, any
//               other non-zero strobe writes only the selected byte lanes.
//               Contents are never cleared.
// Ports       : clk     - clock
//               i_addr  - word index
//               i_we    - byte-lane write enables (0 = no write)
//               i_wdata - write data
//               o_rdata - word at i_addr, registered (one cycle later)
// Revision    : 1.0 - initial release
// ============================================================================

module responder_ram #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we == 4'hF) begin
            r_mem[i_addr] <= i_wdata;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule : responder_ram
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Two-port (instruction / data) memory responder. One access is
//               in flight at a time: IDLE grants a port and latches its
//               request, WAIT burns wait_states cycles, RESP pulses the
//               granted port's ready for one cycle with read data (0 for
//               writes and out-of-range accesses) and commits any write.
//               Ties alternate, starting with the data port.
// Ports       : clock, reset           - clock, synchronous active-high reset
//               imemory_* (valid, instr, addr, wdata, wstrb -> rdata, ready)
//               dmemory_* (same as imemory_*)
// Revision    : 1.0 - initial release
// ============================================================================

module mem_responder
    import mem_responder_cfg_pkg::*;
    import mem_responder_pkg::*;
#(
    parameter int unsigned mem_depth   = c_MEM_DEPTH_DEFAULT,
    parameter int unsigned wait_states = c_WAIT_STATES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imemory_valid,
    input  logic        imemory_instr,
    input  logic [31:0] imemory_addr,
    input  logic [31:0] imemory_wdata,
    input  logic [3:0]  imemory_wstrb,
    output logic [31:0] imemory_rdata,
    output logic        imemory_ready,
    input  logic        dmemory_valid,
    input  logic        dmemory_instr,
    input  logic [31:0] dmemory_addr,
    input  logic [31:0] dmemory_wdata,
    input  logic [3:0]  dmemory_wstrb,
    output logic [31:0] dmemory_rdata,
    output logic        dmemory_ready
);

    localparam int unsigned c_AW        = (mem_depth > 1) ? $clog2(mem_depth) : 1;
    localparam logic [3:0]  c_WAIT_LOAD = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;
    localparam bit          c_NO_WAIT   = (wait_states == 0);

    responder_in_t  w_ireq, w_dreq, w_sel;
    responder_out_t w_iout, w_dout;

    assign w_ireq = {imemory_valid, imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
    assign w_dreq = {dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};

    assign imemory_rdata = w_iout.rdata;
    assign imemory_ready = w_iout.ready;
    assign dmemory_rdata = w_dout.rdata;
    assign dmemory_ready = w_dout.ready;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_last_d;   // 1 = data port won the previous grant
    logic              r_gnt_d;
    logic [c_AW-1:0]   r_idx;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_inrange;
    logic              r_iready, r_dready;
    logic              r_ird_en, r_drd_en;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the port that did not
    // win last time is chosen.
    // ------------------------------------------------------------------
    logic w_any, w_pick_d, w_sel_inrange;

    assign w_any         = w_ireq.valid | w_dreq.valid;
    assign w_pick_d      = w_dreq.valid & (~w_ireq.valid | ~r_last_d);
    assign w_sel         = w_pick_d ? w_dreq : w_ireq;
    assign w_sel_inrange = word_in_range(w_sel.addr, mem_depth);

    // Fields of the selected request that carry no function.
    logic w_unused_ok;
    assign w_unused_ok = ^{w_sel.valid, w_sel.instr, w_sel.addr[1:0]};

    // ------------------------------------------------------------------
    // Next-cycle response decode. With zero wait states the RESP cycle
    // directly follows IDLE, so the live request must be used there;
    // otherwise the latched request is already in place.
    // ------------------------------------------------------------------
    logic w_enter_resp, w_resp_d, w_resp_rd;

    always_comb begin
        w_enter_resp = 1'b0;
        w_resp_d     = r_gnt_d;
        w_resp_rd    = (r_wstrb == 4'd0) && r_inrange;
        case (r_state)
            IDLE: begin
                w_enter_resp = w_any && c_NO_WAIT;
                w_resp_d     = w_pick_d;
                w_resp_rd    = (w_sel.wstrb == 4'd0) && w_sel_inrange;
            end
            WAIT: begin
                w_enter_resp = (r_cnt == 4'd0);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage. The read is issued on the edge entering RESP so its
    // registered output lines up with the ready cycle; the write lands on
    // the edge leaving RESP unless reset is asserted on that edge.
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_ram_addr;
    logic [3:0]      w_ram_we;
    logic [31:0]     w_ram_rdata;

    assign w_ram_addr = (r_state == IDLE) ? w_sel.addr[c_AW+1:2] : r_idx;
    assign w_ram_we   = ((r_state == RESP) && r_inrange && !reset) ? r_wstrb : 4'd0;

    responder_ram #(
        .DEPTH  (mem_depth),
        .ADDR_W (c_AW)
    ) u_ram (
        .clk     (clock),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_last_d <= 1'b0;
            r_iready <= 1'b0;
            r_dready <= 1'b0;
            r_ird_en <= 1'b0;
            r_drd_en <= 1'b0;
        end else begin
            r_iready <= w_enter_resp & ~w_resp_d;
            r_dready <= w_enter_resp &  w_resp_d;
            r_ird_en <= w_enter_resp & ~w_resp_d & w_resp_rd;
            r_drd_en <= w_enter_resp &  w_resp_d & w_resp_rd;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt_d   <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_idx     <= w_sel.addr[c_AW+1:2];
                        r_wdata   <= w_sel.wdata;
                        r_wstrb   <= w_sel.wstrb;
                        r_inrange <= w_sel_inrange;
                        r_cnt     <= c_WAIT_LOAD;
                        r_state   <= c_NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_iout.ready = r_iready;
    assign w_iout.rdata = r_ird_en ? w_ram_rdata : 32'd0;
    assign w_dout.ready = r_dready;
    assign w_dout.rdata = r_drd_en ? w_ram_rdata : 32'd0;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Three instances with
//               wait_states 0, 1 and 4 share one clock. A transaction-level
//               model (due-cycle arithmetic plus a word array) predicts every
//               ready/rdata value; directed sequences pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_responder;

    localparam int c_D = 64;
    localparam int c_N = 3;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 4);
    endfunction

    logic        clk = 1'b0;
    logic        rst [c_N];
    logic        iv  [c_N], dv [c_N], ii [c_N], di [c_N];
    logic [31:0] ia  [c_N], da [c_N], iw [c_N], dw [c_N];
    logic [3:0]  is_ [c_N], ds [c_N];
    logic        ir  [c_N], dr [c_N];
    logic [31:0] ird [c_N], drd [c_N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_N; g++) begin : g_dut
        mem_responder #(
            .mem_depth   (c_D),
            .wait_states (ws_of(g))
        ) u_dut (
            .clock         (clk),
            .reset         (rst[g]),
            .imemory_valid (iv[g]),
            .imemory_instr (ii[g]),
            .imemory_addr  (ia[g]),
            .imemory_wdata (iw[g]),
            .imemory_wstrb (is_[g]),
            .imemory_rdata (ird[g]),
            .imemory_ready (ir[g]),
            .dmemory_valid (dv[g]),
            .dmemory_instr (di[g]),
            .dmemory_addr  (da[g]),
            .dmemory_wdata (dw[g]),
            .dmemory_wstrb (ds[g]),
            .dmemory_rdata (drd[g]),
            .dmemory_ready (dr[g])
        );
    end

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    bit     cmp_en   = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, k, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: an accepted request is due 1+wait_states cycles
    // later; the write lands at the end of the due cycle.
    // ------------------------------------------------------------------
    bit          m_busy [c_N], m_last_d [c_N], m_gd [c_N];
    longint      m_due  [c_N];
    logic [31:0] m_a [c_N], m_wd [c_N];
    logic [3:0]  m_st [c_N];
    logic [31:0] mm [c_N][c_D];
    bit          mk [c_N][c_D];
    bit          e_ir [c_N], e_dr [c_N], e_known [c_N];
    logic [31:0] e_rd [c_N];

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < c_D;
    endfunction

    task automatic model_step(input int k);
        int w;
        if (rst[k]) begin
            m_busy[k] = 0; m_last_d[k] = 0;
            e_ir[k] = 0; e_dr[k] = 0; e_rd[k] = 0; e_known[k] = 1;
            return;
        end
        if (m_busy[k] && cyc == m_due[k]) begin
            if (m_st[k] != 4'd0 && in_rng(m_a[k])) begin
                w = int'(m_a[k] >> 2);
                if (m_st[k] == 4'hF) mk[k][w] = 1;
                for (int b = 0; b < 4; b++)
                    if (m_st[k][b]) mm[k][w][8*b +: 8] = m_wd[k][8*b +: 8];
            end
            m_busy[k] = 0;
        end else if (!m_busy[k] && (iv[k] || dv[k])) begin
            m_gd[k]     = dv[k] && (!iv[k] || !m_last_d[k]);
            m_last_d[k] = m_gd[k];
            m_a[k]      = m_gd[k] ? da[k] : ia[k];
            m_wd[k]     = m_gd[k] ? dw[k] : iw[k];
            m_st[k]     = m_gd[k] ? ds[k] : is_[k];
            m_due[k]    = cyc + 1 + ws_of(k);
            m_busy[k]   = 1;
        end
        e_ir[k] = m_busy[k] && (m_due[k] == cyc + 1) && !m_gd[k];
        e_dr[k] = m_busy[k] && (m_due[k] == cyc + 1) &&  m_gd[k];
        if (m_st[k] == 4'd0 && in_rng(m_a[k])) begin
            e_rd[k]    = mm[k][int'(m_a[k] >> 2)];
            e_known[k] = mk[k][int'(m_a[k] >> 2)];
        end else begin
            e_rd[k]    = 32'd0;
            e_known[k] = 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < c_N; k++) model_step(k);
            cyc++;
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < c_N; k++) begin
                    chk("ready_i", k, {31'd0, ir[k]}, {31'd0, e_ir[k]});
                    chk("ready_d", k, {31'd0, dr[k]}, {31'd0, e_dr[k]});
                    if (!e_ir[k] || e_known[k]) chk("rdata_i", k, ird[k], e_ir[k] ? e_rd[k] : 32'd0);
                    if (!e_dr[k] || e_known[k]) chk("rdata_d", k, drd[k], e_dr[k] ? e_rd[k] : 32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic access(input int k, input bit port_d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output int lat, output logic [31:0] rd);
        @(negedge clk);
        if (port_d) begin dv[k] = 1; da[k] = a; dw[k] = wd; ds[k] = st; end
        else        begin iv[k] = 1; ia[k] = a; iw[k] = wd; is_[k] = st; end
        lat = -1; rd = 32'hFFFF_FFFF;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (port_d ? dr[k] : ir[k]) begin
                lat = i; rd = port_d ? drd[k] : ird[k];
                break;
            end
        end
        if (port_d) dv[k] = 0; else iv[k] = 0;
    endtask

    task automatic do_chk(input string name, input int k, input bit port_d, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st, input logic [31:0] exp_rd);
        int lat; logic [31:0] rd;
        access(k, port_d, a, wd, st, lat, rd);
        chk({name, "_lat"}, k, lat, 1 + ws_of(k));
        chk({name, "_rd"}, k, rd, exp_rd);
    endtask

    task automatic both_req(input int k, output int td, output int ti);
        @(negedge clk);
        dv[k] = 1; da[k] = 32'h40; ds[k] = 0;
        iv[k] = 1; ia[k] = 32'h44; is_[k] = 0;
        td = -1; ti = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (dr[k]) begin td = i; dv[k] = 0; end
            if (ir[k]) begin ti = i; iv[k] = 0; end
            if (td > 0 && ti > 0) break;
        end
        dv[k] = 0; iv[k] = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(99);
        if (r < 90)      return 32'($urandom_range(c_D - 1) * 4 + $urandom_range(3));
        else if (r < 97) return 32'((c_D + $urandom_range(3)) * 4);
        else             return $urandom;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int td, ti, l1, l2, seen;
        logic [31:0] r2;
        for (int k = 0; k < c_N; k++) begin
            rst[k] = 1; iv[k] = 0; dv[k] = 0; ii[k] = 0; di[k] = 0;
            ia[k] = 0; da[k] = 0; iw[k] = 0; dw[k] = 0; is_[k] = 0; ds[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            chk("rst_ready_i", k, {31'd0, ir[k]}, 32'd0);
            chk("rst_ready_d", k, {31'd0, dr[k]}, 32'd0);
            chk("rst_rdata_i", k, ird[k], 32'd0);
            chk("rst_rdata_d", k, drd[k], 32'd0);
        end
        for (int k = 0; k < c_N; k++) rst[k] = 0;
        cmp_en = 1;

        // Write / read / byte lane on wait_states=1
        do_chk("wr40",   1, 1, 32'h40, 32'hDEADBEEF, 4'hF, 32'd0);
        do_chk("rd40",   1, 1, 32'h40, 32'd0,        4'h0, 32'hDEADBEEF);
        do_chk("wrlane", 1, 1, 32'h40, 32'h0000AA00, 4'h2, 32'd0);
        do_chk("rdlane", 1, 1, 32'h40, 32'd0,        4'h0, 32'hDEADAAEF);

        // Simultaneous requests after reset: data first, then instruction
        @(negedge clk); rst[1] = 1;
        @(negedge clk); rst[1] = 0;
        both_req(1, td, ti);
        chk("tie1_d_lat", 1, td, 2);
        chk("tie1_i_lat", 1, ti, 5);
        both_req(1, td, ti);
        chk("tie2_d_lat", 1, td, 2);
        chk("tie2_i_lat", 1, ti, 5);

        // Out of range read and write; word 0 aliases the index bits
        do_chk("wr0",    1, 0, 32'h0,       32'h12345678, 4'hF, 32'd0);
        do_chk("oor_rd", 1, 0, 32'(4*c_D),  32'd0,        4'h0, 32'd0);
        do_chk("oor_wr", 1, 1, 32'(4*c_D),  32'hFFFFFFFF, 4'hF, 32'd0);
        do_chk("rd0",    1, 0, 32'h0,       32'd0,        4'h0, 32'h12345678);

        // Reset during WAIT aborts a pending write (wait_states=4)
        do_chk("wr10", 2, 1, 32'h10, 32'h11111111, 4'hF, 32'd0);
        @(negedge clk); dv[2] = 1; da[2] = 32'h10; dw[2] = 32'hCAFEF00D; ds[2] = 4'hF;
        @(negedge clk);
        @(negedge clk); rst[2] = 1; dv[2] = 0;
        @(negedge clk); rst[2] = 0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (dr[2] || ir[2]) seen = 1; end
        chk("abort_noready", 2, seen, 0);
        do_chk("rd10", 2, 0, 32'h10, 32'd0, 4'h0, 32'h11111111);

        // Zero wait states: latency 1, back-to-back every 2 cycles
        do_chk("ws0_wr8", 0, 0, 32'h8, 32'hA5A55A5A, 4'hF, 32'd0);
        do_chk("ws0_wrC", 0, 0, 32'hC, 32'h0BADC0DE, 4'hF, 32'd0);
        do_chk("ws0_rd8", 0, 0, 32'h8, 32'd0,        4'h0, 32'hA5A55A5A);
        @(negedge clk); iv[0] = 1; ia[0] = 32'h8; is_[0] = 0;
        l1 = -1; l2 = -1; r2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ir[0]) begin
                if (l1 < 0) begin l1 = i; ia[0] = 32'hC; end
                else begin l2 = i; r2 = ird[0]; break; end
            end
        end
        iv[0] = 0;
        chk("b2b_lat1", 0, l1, 1);
        chk("b2b_lat2", 0, l2, 3);
        chk("b2b_rd2",  0, r2, 32'h0BADC0DE);

        // Randomized traffic on all three instances
        repeat (3000) begin
            @(negedge clk);
            for (int k = 0; k < c_N; k++) begin
                if (rst[k]) rst[k] = 0;
                else if ($urandom_range(400) == 0) rst[k] = 1;
                if (iv[k] && ir[k]) iv[k] = 0;
                else if (iv[k] && $urandom_range(99) == 0) iv[k] = 0;
                if (!iv[k] && $urandom_range(2) == 0) begin
                    iv[k] = 1; ia[k] = rand_addr(); iw[k] = $urandom; ii[k] = 1'($urandom);
                    is_[k] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
                end
                if (dv[k] && dr[k]) dv[k] = 0;
                else if (dv[k] && $urandom_range(99) == 0) dv[k] = 0;
                if (!dv[k] && $urandom_range(2) == 0) begin
                    dv[k] = 1; da[k] = rand_addr(); dw[k] = $urandom; di[k] = 1'($urandom);
                    ds[k] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
                end
            end
        end
        for (int k = 0; k < c_N; k++) begin iv[k] = 0; dv[k] = 0; rst[k] = 0; end
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_responder
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter mem_depth, default 4096, storage size in 32-bit words (power of two).
REQ-002 Parameter wait_states, default 1, extra latency cycles per access, range 0..15.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imemory_valid  input  1  instruction-port request; held until imemory_ready.
REQ-006 imemory_instr  input  1  fetch tag; ignored functionally.
REQ-007 imemory_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 imemory_wdata  input  32  write data.
REQ-009 imemory_wstrb  input  4  byte write enables; 0 = read.
REQ-010 imemory_rdata  output  32  read data, valid only while imemory_ready=1.
REQ-011 imemory_ready  output  1  one-cycle completion pulse.
REQ-012 dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb, dmemory_rdata, dmemory_ready: data port with the same directions, widths and meanings as REQ-005..REQ-011.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 IDLE: if any valid=1, grant one port and latch its addr, wdata and wstrb; go to WAIT if wait_states>0, else go to RESP.
REQ-015 Arbitration: a single requester wins; when both request, grant the port not granted last; the last-grant flag resets to instruction, so data wins the first tie.
REQ-016 WAIT: down-counter loaded with wait_states-1 on grant; go to RESP when it reaches 0.
REQ-017 RESP: assert the granted port's ready for exactly one cycle, then go to IDLE.
REQ-018 Latency: request accepted in cycle T; ready asserted in cycle T+1+wait_states.
REQ-019 The ungranted port's ready SHALL stay 0; its request is sampled again in IDLE.
REQ-020 A new request SHALL be accepted no earlier than the cycle after ready; minimum spacing per access is 2+wait_states cycles.
REQ-021 Read (wstrb=0): rdata = word at addr[log2(mem_depth)+1:2], sampled in the ready cycle.
REQ-022 Write: only lanes with wstrb[i]=1 update byte i; commit at the RESP clock edge; rdata=0 in the ready cycle.
REQ-023 Out-of-range address (addr[31:2] >= mem_depth): rdata=0, write dropped, ready still issued.
REQ-024 valid dropped mid-transaction is a protocol violation; the access still completes and ready still pulses.
REQ-025 Outside the ready cycle, rdata of both ports SHALL be 0.

Reset
REQ-026 reset=1 SHALL set state=IDLE, counter=0, last-grant=instruction, and both ready and rdata to 0 from the next edge.
REQ-027 Reset mid-transaction SHALL abort it with no write commit and no ready pulse.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-029 The state enum and a responder_in/out struct pair SHALL live in the shared wires package; mem_depth and wait_states defaults SHALL live in the shared configuration package.
REQ-030 Storage SHALL be a separate sub-module responder_ram: single port, 32-bit, byte-write-enabled, registered read, written with a full-word write or one or more byte-lane writes.
REQ-031 Target size is 120-400 lines of RTL including responder_ram.

Verification
REQ-032 Data write then read, wait_states=1: dmemory write addr 0x40, wdata 0xDEADBEEF, wstrb 0xF -> ready at T+2 with rdata 0. Read of 0x40 -> ready at T+2 with rdata 0xDEADBEEF.
REQ-033 Byte lanes: after REQ-032, write wstrb 0x2 with wdata 0x0000AA00 -> read of 0x40 returns 0xDEADAAEF.
REQ-034 Simultaneous requests after reset: both valid in the same cycle -> data served first, instruction ready 3 cycles later; repeat both -> order alternates.
REQ-035 Out of range: read at addr 4*mem_depth -> ready pulses with rdata 0. Write there -> no word in storage changes.
REQ-036 Reset mid-WAIT (wait_states=4, write pending): reset at T+2 -> no ready pulse, target word unchanged, next request served normally.
REQ-037 wait_states=0: read accepted at T -> ready at T+1; back-to-back reads accepted at T and T+2.
